// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin front end sharing one iterative Fibonacci datapath
// among NUM_REQ requesters. One job in flight; result returned on a single
// tagged response channel with an overflow flag.
module fib_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2,
  parameter int unsigned N_WIDTH  = 6,
  parameter int unsigned WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*N_WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_ovf,
  output logic                       busy
);

  // Width of an index into the requester vector.
  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [SEL_W-1:0]    r_rr_ptr;
  logic [N_WIDTH-1:0]  r_cnt;
  logic [ID_WIDTH-1:0] r_id;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_ca;
  logic                r_cb;
  logic                r_rsp_valid;
  logic [ID_WIDTH-1:0] r_rsp_id;
  logic [WIDTH-1:0]    r_rsp_data;
  logic                r_rsp_ovf;

  logic                w_found;
  logic [SEL_W-1:0]    w_winner;
  logic [SEL_W-1:0]    w_rr_ptr_nxt;
  logic [N_WIDTH-1:0]  w_n_arr [NUM_REQ];
  logic [WIDTH:0]      w_sum;
  logic                w_accept;
  logic                w_step;
  logic                w_finish;
  logic                w_release;

  // Split the flat index bus into one field per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign w_n_arr[g] = req_n[g*N_WIDTH +: N_WIDTH];
  end

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin : arb_search
    int unsigned idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[SEL_W'(idx)]) begin
        w_found  = 1'b1;
        w_winner = SEL_W'(idx);
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  assign w_rr_ptr_nxt = (w_winner == SEL_W'(NUM_REQ - 1)) ? '0 : w_winner + SEL_W'(1);

  // One addition per cycle; the extra bit is the carry out of the WIDTH-bit add.
  assign w_sum = (WIDTH+1)'(r_a) + (WIDTH+1)'(r_b);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Grant is suppressed while reset is held so nothing is offered.
        if (w_found && !reset) begin
          req_ready   = NUM_REQ'(1) << w_winner;
          w_accept    = 1'b1;
          w_state_nxt = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (r_cnt != '0) begin
          w_step = 1'b1;
        end else begin
          w_finish    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbitration pointer advances only on an accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Job capture and iteration: (a,b) walk the sequence, (ca,cb) track
  // whether each of them has ever exceeded WIDTH bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_id  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_ca  <= 1'b0;
      r_cb  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= w_n_arr[w_winner];
      r_id  <= ID_WIDTH'(w_winner);
      r_a   <= '0;
      r_b   <= WIDTH'(1);
      r_ca  <= 1'b0;
      r_cb  <= 1'b0;
    end else if (w_step) begin
      r_a   <= r_b;
      r_b   <= w_sum[WIDTH-1:0];
      r_ca  <= r_cb;
      r_cb  <= r_ca | r_cb | w_sum[WIDTH];
      r_cnt <= r_cnt - N_WIDTH'(1);
    end
  end

  // Response registers: loaded when the count runs out, held until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
    end else if (w_finish) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id;
      r_rsp_data  <= r_a;
      r_rsp_ovf   <= r_ca;
    end else if (w_release) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_ovf   = r_rsp_ovf;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter: directed scenarios plus randomized traffic; a negedge
// monitor predicts grants and results from a behavioural model and scores
// every response popped from the expectation queue.
module tb_fib_arbiter;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned ID_WIDTH = 2;
  localparam int unsigned N_WIDTH  = 6;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned NW_ALL   = NUM_REQ * N_WIDTH;
  localparam int unsigned SEL_W    = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NUM_REQ-1:0]  req_valid = '0;
  logic [NW_ALL-1:0]   req_n = '0;
  logic [NUM_REQ-1:0]  req_ready;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [ID_WIDTH-1:0] rsp_id;
  logic [WIDTH-1:0]    rsp_data;
  logic                rsp_ovf;
  logic                busy;

  fib_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH),
    .N_WIDTH (N_WIDTH),
    .WIDTH   (WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_n    (req_n),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_ovf  (rsp_ovf),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int unsigned       id;
    longint unsigned   data;
    bit                ovf;
    int unsigned       due;
  } exp_t;

  typedef struct {
    int unsigned       id;
    longint unsigned   data;
    bit                ovf;
  } rsp_t;

  exp_t               exp_q[$];
  rsp_t               rsp_log[$];
  int unsigned        grant_log[$];
  int unsigned        pend[NUM_REQ][$];
  int unsigned        cur_n[NUM_REQ];
  int                 checks = 0;
  int                 errors = 0;
  int unsigned        cyc = 0;
  int unsigned        m_ptr = 0;
  bit                 m_busy = 1'b0;
  bit                 prev_rv = 1'b0;
  bit                 rand_mode = 1'b0;
  logic [NUM_REQ-1:0] hs_flags = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic bit bit_of(logic [31:0] v, int unsigned i);
    return v[i[4:0]];
  endfunction

  // Reference Fibonacci in 64-bit arithmetic; n <= 63 never exceeds 64 bits.
  function automatic longint unsigned fib(int unsigned n);
    longint unsigned x = 0;
    longint unsigned y = 1;
    longint unsigned t;
    repeat (n) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: predict grant, score responses, track busy.
  initial begin : mon
    int unsigned        w;
    int unsigned        n;
    int unsigned        j;
    bit                 found;
    logic [NUM_REQ-1:0] exp_rdy;
    longint unsigned    f;
    exp_t               cur;
    cur = '{0, 0, 1'b0, 0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("busy", 64'(busy), 64'(m_busy));
        if (!m_busy) begin
          found = 1'b0;
          w     = 0;
          for (int k = 0; k < int'(NUM_REQ); k++) begin
            j = (m_ptr + k) % NUM_REQ;
            if (!found && bit_of(32'(req_valid), j)) begin
              found = 1'b1;
              w     = j;
            end
          end
          exp_rdy = found ? (NUM_REQ'(1) << w) : '0;
          chk("req_ready_idle", 64'(req_ready), 64'(exp_rdy));
          if (found) begin
            n = 32'(req_n >> (w * N_WIDTH)) & ((32'd1 << N_WIDTH) - 1);
            f = fib(n);
            exp_q.push_back('{w, f & 64'hFFFF_FFFF, (f >> 32) != 0, cyc + n + 2});
            m_ptr = (w + 1) % NUM_REQ;
            grant_log.push_back(w);
            hs_flags |= NUM_REQ'(1) << w;
            m_busy = 1'b1;
          end
        end else begin
          chk("req_ready_busy", 64'(req_ready), 64'd0);
        end
        if (rsp_valid) begin
          if (!prev_rv) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rsp_unexpected: rsp_valid rose with no job outstanding (cycle %0d)", cyc);
            end else begin
              cur = exp_q.pop_front();
              chk("rsp_id", 64'(rsp_id), 64'(cur.id));
              chk("rsp_data", 64'(rsp_data), cur.data);
              chk("rsp_ovf", 64'(rsp_ovf), 64'(cur.ovf));
              chk("rsp_latency", 64'(cyc), 64'(cur.due));
              rsp_log.push_back('{32'(rsp_id), 64'(rsp_data), rsp_ovf});
            end
          end else begin
            chk("rsp_hold_data", 64'(rsp_data), cur.data);
            chk("rsp_hold_id", 64'(rsp_id), 64'(cur.id));
            chk("rsp_hold_ovf", 64'(rsp_ovf), 64'(cur.ovf));
          end
          if (rsp_ready) m_busy = 1'b0;
        end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
          checks++;
          errors++;
          $display("FAIL rsp_timeout: no response for id %0d by cycle %0d (now %0d)",
                   exp_q[0].id, exp_q[0].due, cyc);
          void'(exp_q.pop_front());
        end
        prev_rv = rsp_valid;
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic set_n(int unsigned i, int unsigned n);
    req_n = (req_n & ~(NW_ALL'((1 << N_WIDTH) - 1) << (i * N_WIDTH)))
          | (NW_ALL'(n & ((1 << N_WIDTH) - 1)) << (i * N_WIDTH));
  endtask

  // Advance one cycle and run the requester agents.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (bit_of(32'(hs_flags), i)) begin
        hs_flags  &= ~(NUM_REQ'(1) << i);
        req_valid &= ~(NUM_REQ'(1) << i);
      end
      if (bit_of(32'(req_valid), i)) begin
        if (rand_mode && $urandom_range(0, 15) == 0) begin
          pend[SEL_W'(i)].push_front(cur_n[SEL_W'(i)]);
          req_valid &= ~(NUM_REQ'(1) << i);
        end
      end else if (pend[SEL_W'(i)].size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
        cur_n[SEL_W'(i)] = pend[SEL_W'(i)].pop_front();
        set_n(i, cur_n[SEL_W'(i)]);
        req_valid |= NUM_REQ'(1) << i;
      end
    end
    if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic bit work_left();
    bit r = (req_valid != '0) || m_busy || (exp_q.size() > 0);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pend[SEL_W'(i)].size() > 0) r = 1'b1;
    end
    return r;
  endfunction

  task automatic wait_idle(int budget);
    int c = 0;
    while (work_left() && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: work still pending after %0d cycles", budget);
    end
  endtask

  task automatic wait_rsp(int budget);
    int c = 0;
    while (!rsp_valid && c < budget) begin
      tick();
      c++;
    end
    chk("wait_rsp_valid", 64'(rsp_valid), 64'd1);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, clear the model.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    req_n     = '0;
    hs_flags  = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) pend[SEL_W'(i)].delete();
    exp_q.delete();
    grant_log.delete();
    rsp_log.delete();
    m_ptr   = 0;
    m_busy  = 1'b0;
    prev_rv = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_hold_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_hold_rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;
  endtask

  task automatic chk_order(string name, int unsigned expv[$]);
    chk({name, "_count"}, 64'(grant_log.size()), 64'(expv.size()));
    for (int k = 0; k < expv.size() && k < grant_log.size(); k++) begin
      chk(name, 64'(grant_log[k]), 64'(expv[k]));
    end
  endtask

  initial begin : stim
    int c;
    do_reset();

    // Single request, then an index sweep on requester 1.
    pend[0].push_back(10);
    wait_idle(200);
    chk("t1_count", 64'(rsp_log.size()), 64'd1);
    if (rsp_log.size() == 1) begin
      chk("t1_data", rsp_log[0].data, 64'd55);
      chk("t1_id", 64'(rsp_log[0].id), 64'd0);
    end
    rsp_log.delete();
    pend[1].push_back(0);
    pend[1].push_back(1);
    pend[1].push_back(2);
    pend[1].push_back(20);
    wait_idle(400);

    // Boundary indices around 32-bit overflow.
    rsp_log.delete();
    pend[2].push_back(47);
    pend[2].push_back(48);
    pend[2].push_back(63);
    wait_idle(600);
    chk("t4_count", 64'(rsp_log.size()), 64'd3);
    if (rsp_log.size() == 3) begin
      chk("t4_fib47", rsp_log[0].data, 64'd2971215073);
      chk("t4_ovf47", 64'(rsp_log[0].ovf), 64'd0);
      chk("t4_fib48", rsp_log[1].data, 64'd512559680);
      chk("t4_ovf48", 64'(rsp_log[1].ovf), 64'd1);
      chk("t4_ovf63", 64'(rsp_log[2].ovf), 64'd1);
    end

    // All four contend, then two re-requesting requesters alternate.
    do_reset();
    for (int i = 0; i < int'(NUM_REQ); i++) pend[SEL_W'(i)].push_back(3 + i);
    wait_idle(400);
    chk_order("t3_order_all", '{0, 1, 2, 3});
    grant_log.delete();
    pend[0].push_back(2);
    pend[0].push_back(9);
    pend[2].push_back(8);
    pend[2].push_back(1);
    wait_idle(400);
    chk_order("t3_order_02", '{0, 2, 0, 2});

    // Response back-pressure with a waiting requester.
    do_reset();
    rsp_ready = 1'b0;
    pend[0].push_back(5);
    pend[3].push_back(7);
    wait_rsp(50);
    repeat (5) begin
      tick();
      chk("t5_hold_data", 64'(rsp_data), 64'd5);
      chk("t5_req_ready", 64'(req_ready), 64'd0);
      chk("t5_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    wait_idle(200);
    chk_order("t5_order", '{0, 3});

    // Reset mid-computation, then pointer restarts at 0.
    do_reset();
    pend[0].push_back(30);
    c = 0;
    while (grant_log.size() == 0 && c < 20) begin
      tick();
      c++;
    end
    chk("t6_granted", 64'(grant_log.size()), 64'd1);
    repeat (9) tick();
    do_reset();
    pend[2].push_back(4);
    pend[0].push_back(6);
    wait_idle(200);
    chk_order("t6_order", '{0, 2});

    // Randomized traffic with drops and response back-pressure.
    do_reset();
    rand_mode = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 1) == 0) pend[SEL_W'($urandom_range(0, NUM_REQ - 1))].push_back($urandom_range(0, 10));
      else pend[SEL_W'($urandom_range(0, NUM_REQ - 1))].push_back($urandom_range(0, 63));
      repeat ($urandom_range(0, 20)) tick();
    end
    wait_idle(40000);
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
